// File: rtl/fetch_unit.sv
// Fetch unit: instruction register, PC sequencing for conditional branches,
// register jumps and JAL, plus a saturating retired-commit counter.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcEn,
  input  logic        ir,
  input  logic [15:0] memData,
  input  logic [4:0]  flags,
  input  logic [15:0] rTarget,
  output logic [15:0] pcAddr,
  output logic [15:0] instruction,
  output logic [15:0] linkAddr,
  output logic        taken,
  output logic [15:0] retired
);

  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_link;
  logic        r_taken;
  logic [15:0] r_retired;

  logic        w_flag_c, w_flag_l, w_flag_f, w_flag_z, w_flag_n;
  logic        w_cond;
  logic        w_is_bcond, w_is_jcond, w_is_jal;
  logic        w_redirect;
  logic [15:0] w_pc_inc;
  logic [15:0] w_pc_next;

  assign w_flag_c = flags[4];
  assign w_flag_l = flags[3];
  assign w_flag_f = flags[2];
  assign w_flag_z = flags[1];
  assign w_flag_n = flags[0];

  // Condition code evaluation from instruction[11:8]
  always_comb begin
    w_cond = 1'b0;
    case (r_ir[11:8])
      4'h0:    w_cond = w_flag_z;
      4'h1:    w_cond = ~w_flag_z;
      4'h2:    w_cond = w_flag_c;
      4'h3:    w_cond = ~w_flag_c;
      4'h4:    w_cond = w_flag_l;
      4'h5:    w_cond = ~w_flag_l;
      4'h6:    w_cond = w_flag_n;
      4'h7:    w_cond = ~w_flag_n;
      4'h8:    w_cond = w_flag_f;
      4'h9:    w_cond = ~w_flag_f;
      4'hA:    w_cond = ~w_flag_l & ~w_flag_z;
      4'hB:    w_cond = w_flag_l | w_flag_z;
      4'hC:    w_cond = ~w_flag_n & ~w_flag_z;
      4'hD:    w_cond = w_flag_n | w_flag_z;
      4'hE:    w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_is_bcond = (r_ir[15:12] == 4'hC);
  assign w_is_jcond = (r_ir[15:12] == 4'h4) && (r_ir[7:4] == 4'hC);
  assign w_is_jal   = (r_ir[15:12] == 4'h4) && (r_ir[7:4] == 4'h8);
  assign w_pc_inc   = r_pc + 16'd1;

  // Next-PC select; arithmetic wraps modulo 2^16
  always_comb begin
    w_redirect = 1'b0;
    w_pc_next  = w_pc_inc;
    if (w_is_bcond && w_cond) begin
      w_redirect = 1'b1;
      w_pc_next  = r_pc + {{8{r_ir[7]}}, r_ir[7:0]};
    end else if ((w_is_jcond && w_cond) || w_is_jal) begin
      w_redirect = 1'b1;
      w_pc_next  = rTarget;
    end else begin
      w_redirect = 1'b0;
      w_pc_next  = w_pc_inc;
    end
  end

  // Architectural state: PC, IR, link register, taken pulse, commit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= 16'h0000;
      r_ir      <= 16'h0000;
      r_link    <= 16'h0000;
      r_taken   <= 1'b0;
      r_retired <= 16'h0000;
    end else begin
      if (ir) begin
        r_ir <= memData;
      end
      if (pcEn) begin
        r_pc    <= w_pc_next;
        r_taken <= w_redirect;
        if (w_is_jal) begin
          r_link <= w_pc_inc;
        end
        if (r_retired != 16'hFFFF) begin
          r_retired <= r_retired + 16'd1;
        end
      end else begin
        r_taken <= 1'b0;
      end
    end
  end

  assign pcAddr      = r_pc;
  assign instruction = r_ir;
  assign linkAddr    = r_link;
  assign taken       = r_taken;
  assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a cycle-level reference model and
// hand-computed literal checks for the key scenarios.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcEn = 1'b0;
  logic        ir = 1'b0;
  logic [15:0] memData = 16'h0000;
  logic [4:0]  flags = 5'b00000;
  logic [15:0] rTarget = 16'h0000;
  logic [15:0] pcAddr, instruction, linkAddr, retired;
  logic        taken;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .pcEn(pcEn), .ir(ir), .memData(memData),
    .flags(flags), .rTarget(rTarget), .pcAddr(pcAddr),
    .instruction(instruction), .linkAddr(linkAddr), .taken(taken),
    .retired(retired)
  );

  initial forever #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_pc, m_ir, m_link, m_ret;
  logic        m_taken;

  // Truth table indexed by condition code, built from named flags
  function automatic logic model_cond(input logic [3:0] code, input logic [4:0] f);
    logic c, l, ff, z, n;
    logic [15:0] tbl;
    c = f[4]; l = f[3]; ff = f[2]; z = f[1]; n = f[0];
    tbl = {1'b0, 1'b1, (n | z), (!n && !z), (l | z), (!l && !z), !ff, ff,
           !n, n, !l, l, !c, c, !z, z};
    return tbl[code];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 16'h0000; m_ir <= 16'h0000; m_link <= 16'h0000;
      m_ret <= 16'h0000; m_taken <= 1'b0;
    end else begin
      if (ir) m_ir <= memData;
      m_taken <= 1'b0;
      if (pcEn) begin
        int op, sub, disp;
        logic c;
        op  = int'(m_ir[15:12]);
        sub = int'(m_ir[7:4]);
        disp = int'($signed(m_ir[7:0]));
        c = model_cond(m_ir[11:8], flags);
        m_pc <= 16'(int'(m_pc) + 1);
        if (op == 12 && c) begin
          m_pc <= 16'(int'(m_pc) + disp);
          m_taken <= 1'b1;
        end
        if (op == 4 && ((sub == 12 && c) || sub == 8)) begin
          m_pc <= rTarget;
          m_taken <= 1'b1;
        end
        if (op == 4 && sub == 8) m_link <= 16'(int'(m_pc) + 1);
        m_ret <= (int'(m_ret) + 1 > 65535) ? 16'hFFFF : 16'(int'(m_ret) + 1);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_pc", pcAddr, m_pc);
      chk("model_ir", instruction, m_ir);
      chk("model_link", linkAddr, m_link);
      chk("model_taken", {15'd0, taken}, {15'd0, m_taken});
      chk("model_retired", retired, m_ret);
    end
  end

  task automatic tick(input logic p, input logic i, input logic [15:0] md,
                      input logic [4:0] f, input logic [15:0] rt);
    pcEn = p; ir = i; memData = md; flags = f; rTarget = rt;
    @(negedge clk);
  endtask

  task automatic jump_to(input logic [15:0] a);
    tick(1'b0, 1'b1, 16'h4EC0, 5'b0, 16'h0000);
    tick(1'b1, 1'b0, 16'h0000, 5'b0, a);
  endtask

  initial begin
    #1;
    chk("rst_pc", pcAddr, 16'h0000);
    chk("rst_ir", instruction, 16'h0000);
    chk("rst_taken", {15'd0, taken}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Basic fetch then commit
    tick(1'b0, 1'b1, 16'h0123, 5'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0000, 5'b0, 16'h0);
    chk("basic_ir", instruction, 16'h0123);
    chk("basic_pc", pcAddr, 16'h0001);
    chk("basic_taken", {15'd0, taken}, 16'h0000);
    chk("basic_ret", retired, 16'h0001);

    // BEQ -2 taken, with IR load and jump in the same cycle
    jump_to(16'h0010);
    chk("jump_pc", pcAddr, 16'h0010);
    tick(1'b0, 1'b1, 16'hC0FE, 5'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0000, 5'b00010, 16'h0);
    chk("beq_t_pc", pcAddr, 16'h000E);
    chk("beq_t_taken", {15'd0, taken}, 16'h0001);
    tick(1'b0, 1'b1, 16'h4EC0, 5'b0, 16'h0);
    chk("beq_pulse_end", {15'd0, taken}, 16'h0000);
    tick(1'b1, 1'b1, 16'hC0FE, 5'b0, 16'h0010);
    chk("same_cycle_pc", pcAddr, 16'h0010);
    chk("same_cycle_ir", instruction, 16'hC0FE);
    tick(1'b1, 1'b0, 16'h0000, 5'b00000, 16'h0);
    chk("beq_nt_pc", pcAddr, 16'h0011);
    chk("beq_nt_taken", {15'd0, taken}, 16'h0000);

    // JAL and a false Jcond
    jump_to(16'h0020);
    tick(1'b0, 1'b1, 16'h4087, 5'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0000, 5'b0, 16'h1234);
    chk("jal_pc", pcAddr, 16'h1234);
    chk("jal_link", linkAddr, 16'h0021);
    chk("jal_taken", {15'd0, taken}, 16'h0001);
    tick(1'b0, 1'b1, 16'h40C0, 5'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0000, 5'b00000, 16'h5555);
    chk("jeq_nt_pc", pcAddr, 16'h1235);
    chk("jeq_nt_link", linkAddr, 16'h0021);

    // PC wrap and backward wrap through zero
    jump_to(16'hFFFF);
    tick(1'b0, 1'b1, 16'h0000, 5'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0000, 5'b0, 16'h0);
    chk("wrap_pc", pcAddr, 16'h0000);
    jump_to(16'h0002);
    tick(1'b0, 1'b1, 16'hCEFC, 5'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0000, 5'b0, 16'h0);
    chk("wrap_back_pc", pcAddr, 16'hFFFE);

    // Condition sweep: Bcond +4 from 0100
    for (int code = 0; code < 16; code++) begin
      for (int f = 0; f < 32; f++) begin
        jump_to(16'h0100);
        tick(1'b0, 1'b1, {4'hC, 4'(code), 8'h04}, 5'b0, 16'h0);
        tick(1'b1, 1'b0, 16'h0000, 5'(f), 16'h0);
        chk("sweep_pc", pcAddr,
            model_cond(4'(code), 5'(f)) ? 16'h0104 : 16'h0101);
      end
    end
    // A few sweep points pinned by hand
    jump_to(16'h0100);
    tick(1'b0, 1'b1, 16'hCA04, 5'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0000, 5'b00000, 16'h0);
    chk("lo_clear_pc", pcAddr, 16'h0104);
    jump_to(16'h0100);
    tick(1'b0, 1'b1, 16'hCC04, 5'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0000, 5'b00001, 16'h0);
    chk("lt_n_pc", pcAddr, 16'h0101);
    jump_to(16'h0100);
    tick(1'b0, 1'b1, 16'hC204, 5'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0000, 5'b10000, 16'h0);
    chk("cs_c_pc", pcAddr, 16'h0104);

    // Retired saturation
    tick(1'b0, 1'b1, 16'h0000, 5'b0, 16'h0);
    pcEn = 1'b1; ir = 1'b0;
    repeat (65540) @(negedge clk);
    chk("ret_sat", retired, 16'hFFFF);
    tick(1'b1, 1'b0, 16'h0000, 5'b0, 16'h0);
    chk("ret_sat_hold", retired, 16'hFFFF);

    // Async reset between edges with a pending commit
    pcEn = 1'b1; ir = 1'b1; memData = 16'h4EC0; rTarget = 16'h7777;
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", pcAddr, 16'h0000);
    chk("arst_ir", instruction, 16'h0000);
    chk("arst_link", linkAddr, 16'h0000);
    chk("arst_ret", retired, 16'h0000);
    @(negedge clk);
    pcEn = 1'b0; ir = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("arst_nocommit_pc", pcAddr, 16'h0000);
    chk("arst_nocommit_ret", retired, 16'h0000);
    chk("arst_nocommit_ir", instruction, 16'h0000);
    tick(1'b1, 1'b1, 16'h0456, 5'b0, 16'h0);
    chk("post_rst_pc", pcAddr, 16'h0001);
    chk("post_rst_ir", instruction, 16'h0456);
    chk("post_rst_ret", retired, 16'h0001);
    tick(1'b0, 1'b0, 16'h0000, 5'b0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL expose clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL expose rst, input, 1 bit; reset SHALL be asynchronous and active-high.
REQ-003 The block SHALL expose pcEn, input, 1 bit, a strobe from the control FSM that commits the next-PC computation.
REQ-004 The block SHALL expose ir, input, 1 bit, a strobe from the control FSM that loads the instruction register.
REQ-005 The block SHALL expose memData, input, 16 bits, the instruction memory read data for address pcAddr.
REQ-006 The block SHALL expose flags, input, 5 bits, ordered {C,L,F,Z,N} as bits [4:0], from the flag register.
REQ-007 The block SHALL expose rTarget, input, 16 bits, the register-file value of the register named by instruction[3:0].
REQ-008 The block SHALL expose pcAddr, output, 16 bits, the current PC, driven directly from the PC register to the memory address port.
REQ-009 The block SHALL expose instruction, output, 16 bits, the instruction register contents, feeding both the decoder and the FSM opcode input.
REQ-010 The block SHALL expose linkAddr, output, 16 bits, the registered return address captured on JAL.
REQ-011 The block SHALL expose taken, output, 1 bit, a registered one-cycle pulse indicating a taken branch or jump.
REQ-012 The block SHALL expose retired, output, 16 bits, a count of pcEn commits.

Function
REQ-013 When ir is 1, instruction SHALL load memData at the clock edge; otherwise it SHALL hold.
REQ-014 When pcEn is 1, PC SHALL update at the clock edge as follows, using the current instruction value; otherwise PC SHALL hold.
  - Bcond (instruction[15:12]=4'hC), condition true: PC <= PC + sign-extended instruction[7:0].
  - Jcond (instruction[15:12]=4'h4 and [7:4]=4'hC), condition true: PC <= rTarget.
  - JAL (instruction[15:12]=4'h4 and [7:4]=4'h8): PC <= rTarget and linkAddr <= PC+1, unconditionally.
  - All other cases, including a false condition: PC <= PC+1.
REQ-015 All PC arithmetic SHALL be 16-bit modulo 2^16; overflow SHALL wrap silently (FFFF+1=0000; 0002+disp 8'hFC=FFFE).
REQ-016 The condition field SHALL be instruction[11:8] and SHALL be evaluated combinationally from flags as follows.
  - EQ 0: Z. NE 1: !Z. CS 2: C. CC 3: !C.
  - HI 4: L. LS 5: !L. GT 6: N. LE 7: !N.
  - FS 8: F. FC 9: !F.
  - LO A: !L&!Z. HS B: L|Z. LT C: !N&!Z. GE D: N|Z.
  - UC E: 1. Never F: 0.
REQ-017 taken SHALL be 1 in the cycle after a pcEn edge that selected a non-PC+1 target, and 0 in every other cycle.
REQ-018 retired SHALL increment by 1 on each pcEn edge and SHALL saturate at 16'hFFFF.
REQ-019 When ir and pcEn are asserted in the same cycle, PC SHALL use the old instruction value and the IR SHALL load memData from the old PC.
REQ-020 linkAddr SHALL change only on a JAL commit.

Reset
REQ-021 While rst is 1, PC, instruction, linkAddr and retired SHALL be 16'h0000 and taken SHALL be 0, regardless of clk.
REQ-022 Asserting rst mid-operation SHALL discard any pending commit.
REQ-023 The first edge after rst deasserts SHALL behave as a normal cycle using reset values.

Verification
REQ-024 Reset, then ir=1 with memData=16'h0123, then pcEn=1 -> instruction=0123, pcAddr=0001, taken=0, retired=1.
REQ-025 IR=16'hC0FE (BEQ, disp -2), PC=0010, Z=1, pcEn -> PC=000E, taken=1 for exactly one cycle; the same case with Z=0 -> PC=0011, taken=0.
REQ-026 IR=16'h4E8? JAL form (16'h4087), PC=0020, rTarget=1234, pcEn -> PC=1234, linkAddr=0021, taken=1.
REQ-027 PC=FFFF, non-branch instruction, pcEn -> PC=0000; retired already at FFFF with pcEn -> remains FFFF.
REQ-028 Condition sweep: all 16 condition codes against all 32 flag patterns with Bcond disp=+4 from PC=0100 -> PC is 0104 exactly when REQ-016 is true, else 0101.
REQ-029 Assert rst asynchronously between edges while pcEn=1 -> outputs go to zero immediately and no commit appears after release.
